// File: rtl/cim_pkg.sv
// Shared constants and FSM state type for the CIM accumulation buffer.
// Each 512-bit word carries TILE_N x TILE_N packed ELEM_W-bit signed partial sums.
package cim_pkg;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 512;
    localparam int TILE_N = 6;
    localparam int ELEM_W = 12;
    localparam int SUMS_W = TILE_N * TILE_N * ELEM_W;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DRAIN = 2'd2
    } acc_state_t;

    function automatic logic is_last_addr(input logic [ADDR_W-1:0] addr);
        return addr == LAST_ADDR;
    endfunction

endpackage

// File: rtl/cim_acc_sram.sv
// DEPTH x DATA_W 1R1W scratchpad with registered, write-first read and no reset.
// Port muxing selects the CIM loop ports in IDLE and the sequencer ports otherwise.
module cim_acc_sram
    import cim_pkg::*;
(
    input  logic              clk,
    input  acc_state_t        state_i,
    input  logic              wr_valid_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic              seq_wr_i,
    input  logic [ADDR_W-1:0] seq_wr_addr_i,
    input  logic              seq_rd_i,
    input  logic [ADDR_W-1:0] seq_rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              re;
    logic [ADDR_W-1:0] raddr;

    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        re    = 1'b0;
        raddr = '0;
        if (state_i == IDLE) begin
            we    = wr_valid_i;
            waddr = wr_addr_i;
            wdata = wr_data_i;
            re    = rd_req_i;
            raddr = rd_addr_i;
        end else begin
            // Sequencer writes (clear / drain-clear) always store zero.
            we    = seq_wr_i;
            waddr = seq_wr_addr_i;
            re    = seq_rd_i;
            raddr = seq_rd_addr_i;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rd_data_q <= (we && (waddr == raddr)) ? wdata : mem_q[raddr];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/cim_acc_buffer.sv
// Accumulation scratchpad for the CIM tile adder: read-modify-write loop, bulk clear, drain.
// Optional CIM_ACC_DRAIN_CLEAR_EN zeroes each entry as it is handed off during DRAIN.
module cim_acc_buffer
    import cim_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_valid_o,
    input  logic              wr_valid_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              clear_i,
    input  logic              drain_start_i,
    output logic [DATA_W-1:0] drain_data_o,
    output logic [ADDR_W-1:0] drain_addr_o,
    output logic              drain_valid_o,
    input  logic              drain_ready_i,
    output logic              busy_o
);

    acc_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              mem_valid_q, mem_valid_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              drain_valid_q, drain_valid_d;

    logic              seq_wr;
    logic              seq_rd;
    logic [ADDR_W-1:0] seq_rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              last_cnt;

    assign last_cnt = is_last_addr(cnt_q);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mem_valid_d   = 1'b0;
        mem_addr_d    = mem_addr_q;
        drain_valid_d = drain_valid_q;
        seq_wr        = 1'b0;
        seq_rd        = 1'b0;
        seq_rd_addr   = cnt_q;

        case (state_q)
            IDLE: begin
                mem_valid_d   = rd_req_i;
                cnt_d         = '0;
                drain_valid_d = 1'b0;
                if (rd_req_i) begin
                    mem_addr_d = rd_addr_i;
                end
                if (clear_i) begin
                    state_d = CLEAR;
                end else if (drain_start_i) begin
                    state_d = DRAIN;
                end
            end

            CLEAR: begin
                seq_wr = 1'b1;
                if (last_cnt) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DRAIN: begin
                if (!drain_valid_q) begin
                    // Fetch the first entry; it is presented on the next cycle.
                    seq_rd        = 1'b1;
                    drain_valid_d = 1'b1;
                end else if (drain_ready_i) begin
`ifdef CIM_ACC_DRAIN_CLEAR_EN
                    seq_wr = 1'b1;
`else
                    seq_wr = 1'b0;
`endif
                    if (last_cnt) begin
                        state_d       = IDLE;
                        cnt_d         = '0;
                        drain_valid_d = 1'b0;
                    end else begin
                        // Prefetch the next entry so it appears right after the handshake.
                        cnt_d       = cnt_q + 1'b1;
                        seq_rd      = 1'b1;
                        seq_rd_addr = cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            mem_valid_q   <= 1'b0;
            mem_addr_q    <= '0;
            drain_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mem_valid_q   <= mem_valid_d;
            mem_addr_q    <= mem_addr_d;
            drain_valid_q <= drain_valid_d;
        end
    end

    cim_acc_sram u_sram (
        .clk           (clk),
        .state_i       (state_q),
        .wr_valid_i    (wr_valid_i),
        .wr_addr_i     (wr_addr_i),
        .wr_data_i     (wr_data_i),
        .rd_req_i      (rd_req_i),
        .rd_addr_i     (rd_addr_i),
        .seq_wr_i      (seq_wr),
        .seq_wr_addr_i (cnt_q),
        .seq_rd_i      (seq_rd),
        .seq_rd_addr_i (seq_rd_addr),
        .rd_data_o     (rd_data)
    );

    // The read register is not reset, so data outputs are qualified by their valids.
    assign mem_valid_o   = mem_valid_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_data_o    = mem_valid_q ? rd_data : '0;
    assign drain_valid_o = drain_valid_q;
    assign drain_addr_o  = drain_valid_q ? cnt_q : '0;
    assign drain_data_o  = drain_valid_q ? rd_data : '0;
    assign busy_o        = (state_q != IDLE);

endmodule
